counter_load_sequencer: RTL
===========================

Name: counter_load_sequencer

Overview:
Upstream command stage for the 8-bit loadable up counter. It accepts (start, end) count segments over a valid/ready interface and buffers them in a small FIFO. For each segment it drives the counter's parallel-load and count-enable controls, then watches the counter output until the terminal value is reached. It signals completion and moves on to the next queued segment without idle cycles.

Parameters:
WIDTH, 8, counter/data width
DEPTH, 4, segment FIFO entries; power of 2, >= 2

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  segment command valid
cmd_ready  output  1  FIFO can accept a command
cmd_start  input  WIDTH  value loaded into the counter
cmd_end  input  WIDTH  terminal count value for the segment
go  input  1  run permit; low pauses counting, no state change
cnt_in  input  WIDTH  counter output feedback
data  output  WIDTH  parallel-load value to the counter
load  output  1  counter parallel-load enable
enable  output  1  counter count enable
busy  output  1  segment in progress (state != IDLE)
done  output  1  one-cycle pulse per completed segment
fifo_level  output  $clog2(DEPTH)+1  queued segment count

Behaviour:
- Reset (synchronous, active-high): one clock, synchronous active-high reset, ports clk/reset.
  - Effect: FIFO emptied, state=IDLE, cur_start/cur_end=0.
  - Output values: data=0, load=0, enable=0, busy=0, done=0, fifo_level=0, cmd_ready=1.
  - Reset mid-segment aborts the segment; queued entries are lost.
- FIFO:
  - Push on cmd_valid && cmd_ready; stores {cmd_start, cmd_end}.
  - cmd_ready = (fifo_level < DEPTH), combinational from current level. When full, no push that cycle even if a pop occurs.
  - Pop only in the transitions below, never when empty.
  - Simultaneous push and pop: level unchanged.
  - Pointers wrap modulo DEPTH.
- State machine (IDLE, LOAD, RUN):
  - IDLE: if level > 0, pop into cur_start/cur_end and go to LOAD; else stay.
  - LOAD: lasts exactly one cycle, then RUN.
  - RUN, cnt_in == cur_end: assert done next cycle (registered pulse). If level > 0, pop and go to LOAD (back-to-back); else go to IDLE.
  - RUN otherwise: stay.
- Output decode:
  - load = (state==LOAD); data = cur_start.
  - enable = (state==RUN) && go && (cnt_in != cur_end); combinational from cnt_in.
  - load and enable are never both 1.
- Latency:
  - Command accepted at edge E0 -> LOAD during cycle after E1 -> counter loads at E2 -> first RUN cycle sees cnt_in==start.
  - Segment of N increments: enable high for N go-cycles, done one cycle after cnt_in==end.
- Arithmetic:
  - end < start is legal; the counter wraps 255->0, and the sequencer just waits for equality.
  - start == end completes on the first RUN cycle with zero enable cycles.
- go low in RUN: enable=0, state held; terminal detection still active.
- Feedback assumption: cnt_in is trusted. If the counter is reloaded externally past end, the sequencer keeps waiting until a wrap brings cnt_in to end.

Optional Feature:
- Macro: SEQ_DONE_CNT_EN.
- Defined: adds output done_count [15:0].
  - Increments on each done pulse, saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with cmd_valid=1 held -> during reset all outputs 0, cmd_ready=1, no push. After deassert: first push accepted, fifo_level=1.
- Push (start=10, end=13), go=1, counter model attached:
  - load=1 for one cycle with data=10.
  - enable=1 while cnt_in=10,11,12; enable=0 at 13.
  - done pulses once, then busy=0.
- Push (250, 2) -> counter wraps 255->0. enable high 8 cycles, done after cnt_in==2.
- Push (5,5) then (7,9) back-to-back:
  - first segment: done with zero enable cycles;
  - LOAD for data=7 in the cycle after the first RUN cycle (no IDLE cycle);
  - second done after 2 enables.
- Push 5 commands with cmd_valid held while busy:
  - cmd_ready drops at fifo_level=4;
  - 5th accepted only after a pop;
  - go toggled 1/0 every cycle doubles segment duration with no lost counts.
- Assert reset mid-RUN (cnt_in=11 of 10..13) with 2 entries queued -> next cycle IDLE, fifo_level=0, no done pulse. With SEQ_DONE_CNT_EN: done_count returns to 0.

Source files
------------

// File: rtl/counter_load_sequencer.sv
// Command sequencer for an 8-bit loadable up counter: queues (start, end) segments and drives load/enable until each terminal value is seen.
// Optional build macro SEQ_DONE_CNT_EN adds a saturating done_count output.
module counter_load_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_start,
    input  logic [WIDTH-1:0]         cmd_end,
    input  logic                     go,
    input  logic [WIDTH-1:0]         cnt_in,
    output logic [WIDTH-1:0]         data,
    output logic                     load,
    output logic                     enable,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef SEQ_DONE_CNT_EN
    ,
    output logic [15:0]              done_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] start_val;
        logic [WIDTH-1:0] end_val;
    } seg_t;

    seg_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    state_t           state;
    state_t           next_state;
    logic             push;
    logic             pop;
    logic             at_end;
    logic [WIDTH-1:0] cur_start;
    logic [WIDTH-1:0] cur_end;

    assign cmd_ready  = (level < LVL_W'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign fifo_level = level;
    assign at_end     = (state == RUN) && (cnt_in == cur_end);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and level define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{start_val: cmd_start, end_val: cmd_end};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_start <= '0;
            cur_end   <= '0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            done  <= at_end;
            if (pop) begin
                cur_start <= mem[rd_ptr].start_val;
                cur_end   <= mem[rd_ptr].end_val;
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop        = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: next_state = RUN;
            RUN: begin
                // Terminal value reached: chain straight into the next queued segment.
                if (at_end) begin
                    if (level != '0) begin
                        pop        = 1'b1;
                        next_state = LOAD;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load   = (state == LOAD);
        enable = (state == RUN) && go && (cnt_in != cur_end);
        busy   = (state != IDLE);
        data   = cur_start;
    end

`ifdef SEQ_DONE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            done_count <= '0;
        end else if (done && (done_count != 16'hFFFF)) begin
            done_count <= done_count + 16'd1;
        end
    end
`endif

endmodule
